// File: rtl/mem_bitmask_pipe_pkg.sv
// mem_pkg: shared FSM type and helpers for mem_bitmask_pipe.
// Optional feature macro: MEM_PARITY_EN (enables the parity helper's use).
package mem_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Widest word the parity helper accepts; callers zero-extend into it.
  localparam int PAR_MAX_W = 1024;

  // Address width for a given depth, never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Even parity: the returned bit makes the total number of ones even.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/mem_bitmask_array.sv
// mem_bitmask_array: single-port storage with per-bit masked write and a
// registered read. Out-of-range addresses drop writes and read back zero.
// Optional feature macro: MEM_PARITY_EN (adds a stored even-parity bit per
// word and a registered parity-error flag on reads).
module mem_bitmask_array
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] bit_mask,
  output logic [DATA_W-1:0] rd_data
`ifdef MEM_PARITY_EN
  ,
  output logic              rd_err
`endif
);

`ifdef MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  logic [MEM_W-1:0]  mem [DEPTH];
  logic              addr_ok;
  logic [DATA_W-1:0] cur_data;
  logic [DATA_W-1:0] merged;
  logic [MEM_W-1:0]  wr_word;

  // Power-of-two depths cover the whole address space, so no range check.
  if (DEPTH == (1 << ADDR_W)) begin : g_full
    assign addr_ok = 1'b1;
  end else begin : g_partial
    assign addr_ok = (32'(addr) < 32'(DEPTH));
  end

  // Merge new data into the current word under the bit mask.
  always_comb begin
    cur_data = mem[addr][DATA_W-1:0];
    merged   = (cur_data & ~bit_mask) | (wr_data & bit_mask);
  end

`ifdef MEM_PARITY_EN
  logic [PAR_MAX_W-1:0] par_in;

  // Parity is taken over the merged word so it always matches what is stored.
  always_comb begin
    par_in             = '0;
    par_in[DATA_W-1:0] = merged;
    wr_word            = {even_parity(par_in), merged};
  end
`else
  assign wr_word = merged;
`endif

  // Storage write; contents are never reset, the clear sweep zeroes them.
  always_ff @(posedge clk) begin
    if (wr_en && addr_ok) begin
      mem[addr] <= wr_word;
    end
  end

  // Registered read; holds its value between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
`ifdef MEM_PARITY_EN
      rd_err  <= 1'b0;
`endif
    end else if (rd_en) begin
      if (addr_ok) begin
        rd_data <= mem[addr][DATA_W-1:0];
`ifdef MEM_PARITY_EN
        rd_err  <= ^mem[addr];
`endif
      end else begin
        rd_data <= '0;
`ifdef MEM_PARITY_EN
        rd_err  <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: rtl/mem_bitmask_pipe.sv
// mem_bitmask_pipe: valid/ready front end for a bit-masked single-port memory
// with a zeroing sweep after reset or clr, and a 1- or 2-cycle read pipeline.
// Optional feature macro: MEM_PARITY_EN (adds the rsp_err output).
module mem_bitmask_pipe
  import mem_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 256,
  parameter  int RD_LAT = 1,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_en,
  output logic              ready,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] bit_mask,
  input  logic              clr,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy
`ifdef MEM_PARITY_EN
  ,
  output logic              rsp_err
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              accept;
  logic              arr_wr;
  logic              arr_rd;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_mask;
  logic [DATA_W-1:0] arr_rdata;
  logic              rd_v1;
`ifdef MEM_PARITY_EN
  logic              arr_rerr;
`endif

  assign busy   = (state == CLEAR);
  assign ready  = (state == RUN) && !clr;
  assign accept = c_en && ready;

  // Sweep owns the array port while clearing; otherwise the requester does.
  always_comb begin
    arr_wr    = 1'b0;
    arr_rd    = 1'b0;
    arr_addr  = addr;
    arr_wdata = wr_data;
    arr_mask  = bit_mask;
    if (busy) begin
      arr_wr    = 1'b1;
      arr_addr  = clr_cnt;
      arr_wdata = '0;
      arr_mask  = '1;
    end else begin
      arr_wr = accept && wr;
      arr_rd = accept && !wr;
    end
  end

  // Clear/run FSM with the sweep address counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_cnt == LAST_ADDR) begin
            state   <= RUN;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
          end
        end
        RUN: begin
          if (clr) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  mem_bitmask_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (arr_wr),
    .rd_en    (arr_rd),
    .addr     (arr_addr),
    .wr_data  (arr_wdata),
    .bit_mask (arr_mask),
    .rd_data  (arr_rdata)
`ifdef MEM_PARITY_EN
    ,
    .rd_err   (arr_rerr)
`endif
  );

  // First read stage: marks that the array read register was just loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v1 <= 1'b0;
    end else begin
      rd_v1 <= arr_rd;
    end
  end

  if (RD_LAT == 1) begin : g_lat1
    assign rsp_valid = rd_v1;
    assign rd_data   = arr_rdata;
`ifdef MEM_PARITY_EN
    assign rsp_err   = arr_rerr;
`endif
  end else begin : g_lat2
    logic              v2;
    logic [DATA_W-1:0] d2;
`ifdef MEM_PARITY_EN
    logic              e2;
`endif

    // Extra output stage; only reloads on a delivered read so data holds.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v2 <= 1'b0;
        d2 <= '0;
`ifdef MEM_PARITY_EN
        e2 <= 1'b0;
`endif
      end else begin
        v2 <= rd_v1;
        if (rd_v1) begin
          d2 <= arr_rdata;
`ifdef MEM_PARITY_EN
          e2 <= arr_rerr;
`endif
        end
      end
    end

    assign rsp_valid = v2;
    assign rd_data   = d2;
`ifdef MEM_PARITY_EN
    assign rsp_err   = e2;
`endif
  end

endmodule

// File: tb/tb_mem_bitmask_pipe.sv
// tb_mem_bitmask_pipe: drives one stimulus stream into an RD_LAT=1 and an
// RD_LAT=2 instance and checks both against a behavioural memory model.
// Optional feature macro: MEM_PARITY_EN (adds the parity-error scenario).
module tb_mem_bitmask_pipe;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b0;
  logic              c_en     = 1'b0;
  logic              wr       = 1'b0;
  logic              clr      = 1'b0;
  logic [ADDR_W-1:0] addr     = '0;
  logic [DATA_W-1:0] wr_data  = '0;
  logic [DATA_W-1:0] bit_mask = '0;

  logic              ready1, ready2, rsp_valid1, rsp_valid2, busy1, busy2;
  logic [DATA_W-1:0] rd_data1, rd_data2;
`ifdef MEM_PARITY_EN
  logic              rsp_err1, rsp_err2;
`endif

  always #5 clk = ~clk;

  mem_bitmask_pipe #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .c_en(c_en), .ready(ready1), .wr(wr), .addr(addr),
    .wr_data(wr_data), .bit_mask(bit_mask), .clr(clr), .rsp_valid(rsp_valid1),
    .rd_data(rd_data1), .busy(busy1)
`ifdef MEM_PARITY_EN
    , .rsp_err(rsp_err1)
`endif
  );

  mem_bitmask_pipe #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .c_en(c_en), .ready(ready2), .wr(wr), .addr(addr),
    .wr_data(wr_data), .bit_mask(bit_mask), .clr(clr), .rsp_valid(rsp_valid2),
    .rd_data(rd_data2), .busy(busy2)
`ifdef MEM_PARITY_EN
    , .rsp_err(rsp_err2)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int due; logic [DATA_W-1:0] data; } rsp_t;
  typedef struct { int at;  logic [DATA_W-1:0] data; } seen_t;

  logic [DATA_W-1:0] ref_mem [DEPTH];
  rsp_t              q1[$], q2[$];
  seen_t             log1[$], log2[$];
  int                cyc       = 0;
  int                busy_left = DEPTH;
  logic [DATA_W-1:0] last1     = '0;
  logic [DATA_W-1:0] last2     = '0;

  initial foreach (ref_mem[i]) ref_mem[i] = '0;

  // Model state advances on each rising edge from the driven inputs only.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      busy_left = DEPTH;
      q1.delete();
      q2.delete();
      last1 = '0;
      last2 = '0;
      foreach (ref_mem[i]) ref_mem[i] = '0;
    end else if (busy_left > 0) begin
      busy_left--;
    end else if (clr) begin
      busy_left = DEPTH;
      foreach (ref_mem[i]) ref_mem[i] = '0;
    end else if (c_en) begin
      if (wr) ref_mem[addr] = (ref_mem[addr] & ~bit_mask) | (wr_data & bit_mask);
      else begin
        q1.push_back('{cyc, ref_mem[addr]});
        q2.push_back('{cyc + 1, ref_mem[addr]});
      end
    end
  end

  // Cycle monitor: status outputs and the response streams of both instances.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy1", busy1, busy_left > 0);
      chk("busy2", busy2, busy_left > 0);
      chk("ready1", ready1, (busy_left == 0) && !clr);
      chk("ready2", ready2, (busy_left == 0) && !clr);
      if (rsp_valid1) log1.push_back('{cyc, rd_data1});
      if (rsp_valid2) log2.push_back('{cyc, rd_data2});
      if (q1.size() > 0 && q1[0].due == cyc) begin
        chk("rsp_valid1", rsp_valid1, 1);
        chk("rd_data1", rd_data1, q1[0].data);
        last1 = q1[0].data;
        void'(q1.pop_front());
      end else begin
        chk("rsp_valid1", rsp_valid1, 0);
        chk("rd_hold1", rd_data1, last1);
      end
      if (q2.size() > 0 && q2[0].due == cyc) begin
        chk("rsp_valid2", rsp_valid2, 1);
        chk("rd_data2", rd_data2, q2[0].data);
        last2 = q2[0].data;
        void'(q2.pop_front());
      end else begin
        chk("rsp_valid2", rsp_valid2, 0);
        chk("rd_hold2", rd_data2, last2);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic en, input logic w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] m, input logic c);
    @(posedge clk);
    #2;
    c_en = en; wr = w; addr = a; wr_data = d; bit_mask = m; clr = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0; c_en = 1'b0; clr = 1'b0;
    @(negedge clk);
    chk("rst_busy1", busy1, 1);
    chk("rst_ready1", ready1, 0);
    chk("rst_valid1", rsp_valid1, 0);
    chk("rst_data1", rd_data1, 0);
    chk("rst_valid2", rsp_valid2, 0);
    chk("rst_data2", rd_data2, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Counts busy cycles from the next falling edge; expects a full sweep.
  task automatic wait_sweep(input string tag);
    int n = 0;
    @(negedge clk);
    while (busy1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk(tag, n, DEPTH);
    chk({tag, "_ready"}, ready1, 1);
  endtask

  task automatic read_expect(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    drive(1'b1, 1'b0, a, '0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
    @(negedge clk);
    chk({tag, "_v1"}, rsp_valid1, 1);
    chk({tag, "_d1"}, rd_data1, exp);
    chk({tag, "_v2early"}, rsp_valid2, 0);
    @(negedge clk);
    chk({tag, "_v2"}, rsp_valid2, 1);
    chk({tag, "_d2"}, rd_data2, exp);
    chk({tag, "_v1done"}, rsp_valid1, 0);
  endtask

  task automatic settle();
    int n = 0;
    while (busy1 && n < 600) begin
      n++;
      @(negedge clk);
    end
    chk("settle_busy", busy1, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    apply_reset();
    wait_sweep("sweep_reset");
    read_expect("rd0", 8'd0, 32'h0);
    read_expect("rd255", 8'd255, 32'h0);

    drive(1'b1, 1'b1, 8'd198, 32'h7, 32'h3, 1'b0);
    read_expect("raw1", 8'd198, 32'h3);
    drive(1'b1, 1'b1, 8'd198, 32'hF, 32'h5, 1'b0);
    read_expect("raw2", 8'd198, 32'h7);
    drive(1'b1, 1'b1, 8'd198, 32'hFFFF_FFFF, 32'h0, 1'b0);
    read_expect("mask0", 8'd198, 32'h7);

    // Back-to-back reads must return consecutive, ordered pulses.
    drive(1'b1, 1'b1, 8'd10, 32'hA, 32'hFFFF_FFFF, 1'b0);
    drive(1'b1, 1'b1, 8'd11, 32'hB, 32'hFFFF_FFFF, 1'b0);
    drive(1'b1, 1'b1, 8'd12, 32'hC, 32'hFFFF_FFFF, 1'b0);
    idle(1);
    log1.delete();
    log2.delete();
    drive(1'b1, 1'b0, 8'd10, '0, '0, 1'b0);
    drive(1'b1, 1'b0, 8'd11, '0, '0, 1'b0);
    drive(1'b1, 1'b0, 8'd12, '0, '0, 1'b0);
    idle(4);
    chk("b2b_cnt1", log1.size(), 3);
    chk("b2b_cnt2", log2.size(), 3);
    if (log1.size() == 3 && log2.size() == 3) begin
      chk("b2b_d1_0", log1[0].data, 32'hA);
      chk("b2b_d1_1", log1[1].data, 32'hB);
      chk("b2b_d1_2", log1[2].data, 32'hC);
      chk("b2b_d2_2", log2[2].data, 32'hC);
      chk("b2b_gap1", log1[2].at - log1[0].at, 2);
      chk("b2b_lag2", log2[0].at - log1[0].at, 1);
    end

    // clr wins over a same-cycle write.
    drive(1'b1, 1'b1, 8'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    @(negedge clk);
    chk("clr_ready", ready1, 0);
    idle(1);
    wait_sweep("sweep_clr");
    read_expect("clr_rd5", 8'd5, 32'h0);

    // A read in flight when clr arrives still returns pre-clear data.
    drive(1'b1, 1'b1, 8'd20, 32'h1234, 32'hFFFF_FFFF, 1'b0);
    idle(1);
    log1.delete();
    log2.delete();
    drive(1'b1, 1'b0, 8'd20, '0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
    idle(1);
    wait_sweep("sweep_inflight");
    chk("inflight_cnt1", log1.size(), 1);
    chk("inflight_cnt2", log2.size(), 1);
    if (log1.size() == 1 && log2.size() == 1) begin
      chk("inflight_d1", log1[0].data, 32'h1234);
      chk("inflight_d2", log2[0].data, 32'h1234);
    end
    read_expect("inflight_after", 8'd20, 32'h0);

    // Reset discards an in-flight read and restarts a sweep in progress.
    drive(1'b1, 1'b1, 8'd30, 32'hDEAD, 32'hFFFF_FFFF, 1'b0);
    drive(1'b1, 1'b0, 8'd30, '0, '0, 1'b0);
    apply_reset();
    repeat (100) @(posedge clk);
    apply_reset();
    wait_sweep("sweep_restart");
    read_expect("rst_rd30", 8'd30, 32'h0);

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)),
            8'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15)),
            32'($urandom),
            ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom),
            $urandom_range(0, 499) == 0);
    end
    idle(4);
    chk("drain1", q1.size(), 0);
    chk("drain2", q2.size(), 0);
    settle();

`ifdef MEM_PARITY_EN
    drive(1'b1, 1'b1, 8'd3, 32'h5, 32'hFFFF_FFFF, 1'b0);
    drive(1'b1, 1'b0, 8'd3, '0, '0, 1'b0);
    idle(1);
    @(negedge clk);
    chk("par_ok1", rsp_err1, 0);
    @(negedge clk);
    chk("par_ok2", rsp_err2, 0);
    dut1.u_array.mem[3][DATA_W] = ~dut1.u_array.mem[3][DATA_W];
    dut2.u_array.mem[3][DATA_W] = ~dut2.u_array.mem[3][DATA_W];
    drive(1'b1, 1'b0, 8'd3, '0, '0, 1'b0);
    idle(1);
    @(negedge clk);
    chk("par_err_v1", rsp_valid1, 1);
    chk("par_err1", rsp_err1, 1);
    @(negedge clk);
    chk("par_err_v2", rsp_valid2, 1);
    chk("par_err2", rsp_err2, 1);
    idle(2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bitmask_pipe.md
Name: mem_bitmask_pipe

Overview:
Parametrised single-port synchronous memory with per-bit write mask. It is the successor to the fixed 256x32 bit-masked memory.
- Adds a valid/ready request interface, a configurable read latency and response-valid signalling.
- Adds a hardware clear sweep after reset or on demand.
- Sits between bus-side agents and on-chip storage; one operation (read or masked write) per accepted cycle.

Parameters:
DATA_W, 32, word width in bits (mask width equals DATA_W)
DEPTH, 256, number of words; must be >= 2
ADDR_W, $clog2(DEPTH), address width (derived, not overridden)
RD_LAT, 1, read latency in cycles from accept edge to rsp_valid; legal values 1 or 2

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
c_en  in  1  request valid (chip enable)
ready  out  1  block can accept a request this cycle
wr  in  1  1 = masked write, 0 = read; sampled with c_en
addr  in  ADDR_W  word address
wr_data  in  DATA_W  write data
bit_mask  in  DATA_W  per-bit write enable, 1 = bit updated
clr  in  1  request full-array clear (pulse)
rsp_valid  out  1  read data valid
rd_data  out  DATA_W  read data, meaningful only when rsp_valid=1
busy  out  1  clear sweep in progress

Behaviour:
- Accept = c_en & ready. Unaccepted requests are dropped; the requester must hold them.
- FSM states:
  - CLEAR: counter walks addr 0..DEPTH-1, writing all-zero, one word per cycle. ready=0, busy=1. After writing DEPTH-1 it goes to RUN. The sweep takes exactly DEPTH cycles.
  - RUN: ready = ~clr (combinational). If clr=1, go to CLEAR with counter=0. clr takes priority over a same-cycle request, which is not accepted.
- Reset: async assert forces state=CLEAR, counter=0, rsp_valid=0, rd_data=0, read pipeline cleared. Array contents are not reset directly; the sweep zeroes them. Reset mid-sweep restarts at address 0. Reset with reads in flight discards them.
- Masked write (accepted, wr=1): at the accept edge, mem[addr] <= (mem[addr] & ~bit_mask) | (wr_data & bit_mask). bit_mask=0 leaves the word unchanged but still counts as an accepted op. No response is generated.
- Read (accepted, wr=0):
  - RD_LAT=1: rsp_valid=1 and rd_data=mem[addr] on the cycle after the accept edge.
  - RD_LAT=2: one extra output register stage.
  - rsp_valid is a one-cycle pulse per read; back-to-back reads give back-to-back pulses, in order.
  - rd_data holds its last value when rsp_valid=0.
- Read-after-write: a write accepted at edge N is visible to a read accepted at edge N+1 or later. A single port cannot issue both in one cycle.
- clr during in-flight reads: responses already in the pipeline are still delivered with the pre-clear data. New requests are blocked until busy falls.
- addr >= DEPTH (non-power-of-2 DEPTH): a write is ignored, a read returns 0 with rsp_valid=1.

Optional Feature:
MEM_PARITY_EN
- Defined:
  - Each word stores an extra even-parity bit, computed over the merged word on every write, including clear writes.
  - Reads recompute parity; a mismatch drives output rsp_err=1, aligned with rsp_valid.
  - rsp_err resets to 0.
- Undefined: no parity storage, no rsp_err port, array width is DATA_W.

Decomposition:
- Package mem_pkg:
  - FSM state enum (CLEAR, RUN).
  - Localparam helper for ADDR_W.
  - Parity function (used when MEM_PARITY_EN is defined).
- Sub-module mem_bitmask_array: pure storage with registered read and masked-write merge, width DATA_W(+1).
- Top holds the FSM, clear counter, accept logic and the RD_LAT pipeline.

Test Plan:
- Reset, hold c_en=0 -> busy=1 and ready=0 for exactly 256 cycles; then ready=1. A read of addr 0 and of addr 255 each return 0x0.
- Write addr 198, wr_data=0x7, bit_mask=0x3; then read 198 -> rsp_valid one cycle after accept (RD_LAT=1), rd_data=0x3.
- Follow-up write addr 198, wr_data=0xF, bit_mask=0x5; then read 198 -> rd_data=0x7. Repeat with RD_LAT=2 -> same data, rsp_valid two cycles after accept.
- Back-to-back reads of addr 10, 11, 12 preloaded with 0xA, 0xB, 0xC -> three consecutive rsp_valid pulses with data 0xA, 0xB, 0xC in order.
- clr and c_en asserted in the same cycle with a write of 0xFFFF_FFFF to addr 5 -> write not accepted, ready=0 for 256 cycles, subsequent read of addr 5 returns 0x0.
- Assert rst_n=0 at sweep count 100 -> sweep restarts, busy stays high a full 256 cycles after release. With MEM_PARITY_EN defined, a forced parity-bit flip on addr 3 makes the next read of addr 3 give rsp_err=1.
